// File: rtl/mux_2x1_arbiter.sv
// -----------------------------------------------------------------------------
// mux_2x1_arbiter
//
// Purpose
//   Two requesters (A and B) share one 3-bit data path. A small FSM
//   (IDLE / GRANT_A / GRANT_B) decides who owns the path.
//   - Ties are broken round-robin against the most recent owner.
//   - An owner that keeps requesting gets HOLD_CYCLES consecutive cycles.
//     After that the grant passes to the other side if it is waiting.
//     If the other side is not waiting, the owner is re-granted with a
//     fresh hold window.
//   The granted data is registered into m one cycle after the grant is
//   visible.
//
// Ports
//   clk    in   1  clock, rising edge
//   reset  in   1  synchronous active-high reset
//   req_a  in   1  requester A wants the path
//   x      in   3  requester A data
//   req_b  in   1  requester B wants the path
//   y      in   3  requester B data
//   gnt_a  out  1  A owns the path (decoded from the state register)
//   gnt_b  out  1  B owns the path (decoded from the state register)
//   s      out  1  mux select, 0 -> x, 1 -> y
//   m      out  3  registered path output
//   valid  out  1  m carries granted data
// -----------------------------------------------------------------------------

// 2:1 mux primitive for the 3-bit path, built bit by bit.
module mux_2x1_3b (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       sel,
    output logic [2:0] y
);
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bit
            assign y[gi] = sel ? b[gi] : a[gi];
        end
    endgenerate
endmodule

module mux_2x1_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic [2:0] x,
    input  logic       req_b,
    input  logic [2:0] y,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       s,
    output logic [2:0] m,
    output logic       valid
);

    // An out-of-range HOLD_CYCLES is clamped into 1..15.
    // This keeps the 4-bit counter compare meaningful.
    localparam int HOLD_EFF = (HOLD_CYCLES < 1)  ? 1  :
                              (HOLD_CYCLES > 15) ? 15 : HOLD_CYCLES;
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_EFF - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       last_reg, last_next;   // 0 = A was granted last, 1 = B
    logic [2:0] m_reg, m_next;
    logic       valid_reg, valid_next;

    logic       owner_req;
    logic       other_req;
    state_t     other_state;
    logic       grant_entry;
    logic       path_active;
    logic [2:0] mux_out;

    // Grant outputs decode the state register only. Because of this,
    // no request input can reach a grant output combinationally.
    assign gnt_a = (state_reg == GRANT_A);
    assign gnt_b = (state_reg == GRANT_B);
    assign s     = (state_reg == GRANT_B);
    assign m     = m_reg;
    assign valid = valid_reg;

    assign path_active = gnt_a | gnt_b;

    // Requests seen from the current owner's point of view.
    // In IDLE these signals are don't-care.
    assign owner_req   = (state_reg == GRANT_B) ? req_b : req_a;
    assign other_req   = (state_reg == GRANT_B) ? req_a : req_b;
    assign other_state = (state_reg == GRANT_B) ? GRANT_A : GRANT_B;

    mux_2x1_3b u_path_mux (
        .a   (x),
        .b   (y),
        .sel (s),
        .y   (mux_out)
    );

    // Next-state logic
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        last_next   = last_reg;
        grant_entry = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req_a && req_b) begin
                    // Tie: serve whoever was not served last.
                    state_next  = last_reg ? GRANT_A : GRANT_B;
                    grant_entry = 1'b1;
                end else if (req_a) begin
                    state_next  = GRANT_A;
                    grant_entry = 1'b1;
                end else if (req_b) begin
                    state_next  = GRANT_B;
                    grant_entry = 1'b1;
                end
            end

            GRANT_A, GRANT_B: begin
                if (!owner_req) begin
                    // Owner let go: hand over directly, or fall back to IDLE.
                    if (other_req) begin
                        state_next  = other_state;
                        grant_entry = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (cnt_reg == HOLD_LAST) begin
                    // Hold window used up. Pass the grant if the other
                    // side waits; otherwise re-enter the same grant,
                    // which restarts the window.
                    state_next  = other_req ? other_state : state_reg;
                    grant_entry = 1'b1;
                end else begin
                    // Mid-window: the other request is ignored.
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (grant_entry) begin
            cnt_next  = 4'd0;
            last_next = (state_next == GRANT_B);
        end else if (state_next == IDLE) begin
            cnt_next = 4'd0;
        end
    end

    // Data path: the mux output is captured only while a grant is active.
    always_comb begin
        m_next     = path_active ? mux_out : 3'b000;
        valid_next = path_active;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            last_reg  <= 1'b1;          // A wins the first tie
            m_reg     <= 3'b000;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
            m_reg     <= m_next;
            valid_reg <= valid_next;
        end
    end

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
module tb_mux_2x1_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b;
    logic [2:0] x, y;

    logic       gnt_a0, gnt_b0, s0, valid0;
    logic [2:0] m0;
    logic       gnt_a1, gnt_b1, s1, valid1;
    logic [2:0] m1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state, one slot per DUT instance.
    // owner is 0 = none, 1 = A, 2 = B.
    // tenure is the number of cycles the owner has held the path
    // since its latest grant entry.
    int         owner  [2];
    int         tenure [2];
    int         last_o [2];
    int         hold   [2];
    logic [2:0] m_exp  [2];
    logic       v_exp  [2];

    always #5 clk = ~clk;

    mux_2x1_arbiter #(.HOLD_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req_a (req_a),
        .x     (x),
        .req_b (req_b),
        .y     (y),
        .gnt_a (gnt_a0),
        .gnt_b (gnt_b0),
        .s     (s0),
        .m     (m0),
        .valid (valid0)
    );

    mux_2x1_arbiter #(.HOLD_CYCLES(1)) dut_h1 (
        .clk   (clk),
        .reset (reset),
        .req_a (req_a),
        .x     (x),
        .req_b (req_b),
        .y     (y),
        .gnt_a (gnt_a1),
        .gnt_b (gnt_b1),
        .s     (s1),
        .m     (m1),
        .valid (valid1)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One rising edge of the arbiter rules applied to model slot k.
    task automatic model_edge(input int k, input logic rst, input logic ra, input logic rb,
                              input logic [2:0] xv, input logic [2:0] yv);
        int  nxt;
        bit  mine, other;
        bit  entered;
        if (rst) begin
            owner[k]  = 0;
            tenure[k] = 0;
            last_o[k] = 2;
            m_exp[k]  = 3'b000;
            v_exp[k]  = 1'b0;
            return;
        end
        // Data follows the owner that was in place before this edge.
        m_exp[k] = (owner[k] == 1) ? xv : (owner[k] == 2) ? yv : 3'b000;
        v_exp[k] = (owner[k] != 0);
        entered  = 1'b0;
        nxt      = owner[k];
        if (owner[k] == 0) begin
            if (ra && rb) nxt = (last_o[k] == 2) ? 1 : 2;
            else if (ra)  nxt = 1;
            else if (rb)  nxt = 2;
            entered = (nxt != 0);
        end else begin
            mine  = (owner[k] == 1) ? ra : rb;
            other = (owner[k] == 1) ? rb : ra;
            if (!mine) begin
                nxt     = other ? 3 - owner[k] : 0;
                entered = other;
            end else if (tenure[k] >= hold[k]) begin
                nxt     = other ? 3 - owner[k] : owner[k];
                entered = 1'b1;
            end else begin
                tenure[k]++;
            end
        end
        owner[k] = nxt;
        if (entered) begin
            tenure[k] = 1;
            last_o[k] = nxt;
        end
    endtask

    task automatic compare_all();
        logic ga, gb, ss, vv;
        logic [2:0] mm;
        for (int k = 0; k < 2; k++) begin
            ga = (k == 0) ? gnt_a0 : gnt_a1;
            gb = (k == 0) ? gnt_b0 : gnt_b1;
            ss = (k == 0) ? s0     : s1;
            vv = (k == 0) ? valid0 : valid1;
            mm = (k == 0) ? m0     : m1;
            check_val($sformatf("h%0d_gnt_a", hold[k]), 32'(ga), 32'(owner[k] == 1));
            check_val($sformatf("h%0d_gnt_b", hold[k]), 32'(gb), 32'(owner[k] == 2));
            check_val($sformatf("h%0d_s", hold[k]),     32'(ss), 32'(owner[k] == 2));
            check_val($sformatf("h%0d_m", hold[k]),     32'(mm), 32'(m_exp[k]));
            check_val($sformatf("h%0d_valid", hold[k]), 32'(vv), 32'(v_exp[k]));
            check_val($sformatf("h%0d_excl", hold[k]),  32'(ga & gb), 32'(0));
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, update the model,
    // then compare just after the edge.
    task automatic step(input logic rst, input logic ra, input logic rb,
                        input logic [2:0] xv, input logic [2:0] yv);
        reset = rst;
        req_a = ra;
        req_b = rb;
        x     = xv;
        y     = yv;
        @(posedge clk);
        model_edge(0, rst, ra, rb, xv, yv);
        model_edge(1, rst, ra, rb, xv, yv);
        #1;
        cyc++;
        $display("cyc=%0d rst=%0b ra=%0b rb=%0b x=%0d y=%0d | h4 ga=%0b gb=%0b m=%0d v=%0b | h1 ga=%0b gb=%0b m=%0d v=%0b",
                 cyc, rst, ra, rb, xv, yv, gnt_a0, gnt_b0, m0, valid0, gnt_a1, gnt_b1, m1, valid1);
        compare_all();
    endtask

    initial begin
        hold[0] = 4;
        hold[1] = 1;
        for (int k = 0; k < 2; k++) begin
            owner[k] = 0; tenure[k] = 0; last_o[k] = 2;
            m_exp[k] = 3'b000; v_exp[k] = 1'b0;
        end

        // Reset state
        step(1, 1, 1, 3'd7, 3'd7);
        step(1, 0, 0, 3'd0, 3'd0);
        check_val("reset_valid", 32'(valid0), 32'(0));
        check_val("reset_m",     32'(m0),     32'(0));

        // A alone: granted continuously, data 101 one cycle later
        for (int i = 0; i < 12; i++) step(0, 1, 0, 3'b101, 3'b000);
        check_val("a_only_gnt_a", 32'(gnt_a0), 32'(1));
        check_val("a_only_m",     32'(m0),     32'(3'b101));
        check_val("a_only_valid", 32'(valid0), 32'(1));

        // Both requesting: 4/4 alternation (every cycle for the HOLD=1 copy)
        step(1, 0, 0, 3'b011, 3'b110);
        for (int i = 0; i < 20; i++) step(0, 1, 1, 3'b011, 3'b110);

        // A drops in cycle 2 of its hold while B waits: direct hand-over
        step(1, 0, 0, 3'd1, 3'd2);
        step(0, 1, 0, 3'd1, 3'd2);
        step(0, 1, 0, 3'd1, 3'd2);
        step(0, 0, 1, 3'd1, 3'd2);
        check_val("handover_gnt_b", 32'(gnt_b0), 32'(1));
        check_val("handover_s",     32'(s0),     32'(1));

        // B drops with A idle: IDLE next, data cleared one cycle later
        step(0, 0, 0, 3'd1, 3'd2);
        check_val("drop_gnt_b",  32'(gnt_b0), 32'(0));
        check_val("drop_valid1", 32'(valid0), 32'(1));
        step(0, 0, 0, 3'd1, 3'd2);
        check_val("drop_valid2", 32'(valid0), 32'(0));
        check_val("drop_m2",     32'(m0),     32'(0));

        // Tie after a B grant -> A; tie after an A grant -> B
        step(0, 1, 1, 3'd3, 3'd4);
        check_val("tie_after_b", 32'(gnt_a0), 32'(1));
        step(0, 0, 0, 3'd3, 3'd4);
        step(0, 1, 1, 3'd3, 3'd4);
        check_val("tie_after_a", 32'(gnt_b0), 32'(1));

        // Reset in the middle of a B grant with req_b held
        step(0, 0, 1, 3'd3, 3'd5);
        step(1, 0, 1, 3'd3, 3'd5);
        check_val("midrst_gnt_b", 32'(gnt_b0), 32'(0));
        check_val("midrst_valid", 32'(valid0), 32'(0));
        check_val("midrst_m",     32'(m0),     32'(0));
        step(0, 0, 1, 3'd3, 3'd5);
        check_val("post_rst_gnt_b", 32'(gnt_b0), 32'(1));

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_2x1_arbiter.md
MUX_2X1_ARBITER -- requirements
Module: mux_2x1_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: maximum consecutive cycles one requester keeps the grant; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 req_a  input  1  requester A wants the shared 3-bit path.
REQ-005 x  input  3  requester A data.
REQ-006 req_b  input  1  requester B wants the shared 3-bit path.
REQ-007 y  input  3  requester B data.
REQ-008 gnt_a  output  1  A currently owns the path.
REQ-009 gnt_b  output  1  B currently owns the path.
REQ-010 s  output  1  mux select: 0 selects x, 1 selects y.
REQ-011 m  output  3  registered path output.
REQ-012 valid  output  1  m carries granted data this cycle.

Function
REQ-013 The block SHALL implement three states: IDLE, GRANT_A, GRANT_B; gnt_a=1 only in GRANT_A, gnt_b=1 only in GRANT_B; gnt_a and gnt_b SHALL never both be 1.
REQ-014 s SHALL be 1 in GRANT_B and 0 in every other state; all grant outputs decode the registered state only (no input-to-grant combinational path).
REQ-015 A 1-bit last register SHALL record the most recently granted requester (0=A, 1=B), updated on entry to GRANT_A/GRANT_B.
REQ-016 From IDLE: req_a only -> GRANT_A; req_b only -> GRANT_B; both -> the requester NOT named by last; neither -> stay IDLE.
REQ-017 Grant latency SHALL be one cycle: request sampled at edge n yields grant visible after edge n.
REQ-018 A 4-bit hold counter SHALL clear on every grant entry and increment each cycle the state remains in the same grant.
REQ-019 In GRANT_X, owner request low -> other request high ? GRANT_other : IDLE.
REQ-020 In GRANT_X, owner request high and counter = HOLD_CYCLES-1 -> other request high ? GRANT_other : re-enter GRANT_X with counter cleared.
REQ-021 In GRANT_X, owner request high and counter < HOLD_CYCLES-1 -> stay; the other request is ignored.
REQ-022 Direct GRANT_A<->GRANT_B switches SHALL NOT pass through IDLE.
REQ-023 m SHALL register x when state is GRANT_A, y when GRANT_B, and 3'b000 in IDLE; valid SHALL register 1 in either grant state, else 0; data therefore lags grant by one cycle.
REQ-024 The select path SHALL be realised by the team's 2:1 3-bit mux primitive driven by s, followed by the m register.
REQ-025 With HOLD_CYCLES=1 and both requesting continuously, grants SHALL alternate every cycle.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, counter=0, last=1 (so A wins the first tie), m=3'b000, valid=0, gnt_a=0, gnt_b=0, s=0, overriding all other inputs, including mid-grant.
REQ-027 After reset deasserts, arbitration SHALL resume at the next edge per REQ-016.

Verification (HOLD_CYCLES=4)
REQ-028 Reset mid-GRANT_B with req_b held -> next cycle all outputs 0/IDLE; first edge after release grants B (only requester).
REQ-029 req_a=1, x=3'b101 from cycle 0, req_b=0 -> gnt_a=1 from cycle 1, m=3'b101, valid=1 from cycle 2, grant renewed every 4 cycles without drop.
REQ-030 req_a and req_b both 1 from reset release, x=3'b011, y=3'b110 -> A granted 4 cycles, B 4 cycles, repeating; m toggles 011/110 one cycle behind grant; never both grants.
REQ-031 In GRANT_A, req_a falls in cycle 2 of hold with req_b=1 -> GRANT_B next cycle, s=1, no IDLE cycle.
REQ-032 In GRANT_B, req_b falls with req_a=0 -> IDLE next cycle; valid=0 and m=3'b000 one cycle later.
REQ-033 Tie from IDLE right after a B grant -> A granted; right after an A grant -> B granted.
